// File: rtl/tcdm_error_slave.sv
// tcdm_error_slave: terminating TCDM slave for unmatched crossbar requests.
// Grants every request and answers one cycle later with an error response.
//
// Ports:
//   clk_i, rst_i            clock, async active-high reset
//   req_i/add_i/wen_i/      TCDM request (wen_i=1 is a read)
//   wdata_i/be_i
//   gnt_o                   grant, equal to req_i
//   r_valid_o/r_opc_o/      response, r_opc_o=1 whenever valid
//   r_rdata_o
//   clr_i                   clears capture state and counter
//   err_*_o                 first-error capture, counter, overflow, irq
//
// Build option: define TCDM_ERR_SLAVE_CAPTURE_EN to include the capture
// FSM, error counter, overflow flag and irq; otherwise those outputs are 0.

module tcdm_error_slave #(
  parameter logic [31:0] RDATA_PATTERN = 32'hBADACCE5,
  parameter int unsigned CNT_WIDTH     = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_i,
  input  logic [31:0]          add_i,
  input  logic                 wen_i,
  input  logic [31:0]          wdata_i,
  input  logic [3:0]           be_i,
  output logic                 gnt_o,
  output logic                 r_valid_o,
  output logic                 r_opc_o,
  output logic [31:0]          r_rdata_o,
  input  logic                 clr_i,
  output logic [31:0]          err_addr_o,
  output logic                 err_wen_o,
  output logic [3:0]           err_be_o,
  output logic                 err_valid_o,
  output logic                 err_overflow_o,
  output logic [CNT_WIDTH-1:0] err_cnt_o,
  output logic                 err_irq_o
);

  logic r_resp_valid;
  logic r_resp_is_read;

  assign gnt_o = req_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_resp_valid   <= 1'b0;
      r_resp_is_read <= 1'b0;
    end else begin
      r_resp_valid   <= req_i;
      r_resp_is_read <= req_i & wen_i;
    end
  end

  assign r_valid_o = r_resp_valid;
  assign r_opc_o   = r_resp_valid;
  assign r_rdata_o = (r_resp_valid && r_resp_is_read) ?
                     RDATA_PATTERN : 32'h0;

`ifdef TCDM_ERR_SLAVE_CAPTURE_EN

  typedef enum logic {
    ST_EMPTY    = 1'b0,
    ST_CAPTURED = 1'b1
  } cap_state_e;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  cap_state_e           r_state;
  cap_state_e           w_state_nxt;
  cap_state_e           w_state_eff;
  logic [31:0]          r_err_addr;
  logic                 r_err_wen;
  logic [3:0]           r_err_be;
  logic                 r_ovf;
  logic                 w_ovf_nxt;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [CNT_WIDTH-1:0] w_cnt_base;
  logic [CNT_WIDTH-1:0] w_cnt_nxt;
  logic                 r_irq;
  logic                 w_irq_nxt;
  logic                 w_load;
  logic [31:0]          w_unused;

  assign w_unused = wdata_i;

  // A clear in the same cycle as a request is applied first, so the
  // request is then handled as if the FSM were already empty.
  always_comb begin
    w_state_eff = clr_i ? ST_EMPTY : r_state;
    w_state_nxt = w_state_eff;
    w_ovf_nxt   = clr_i ? 1'b0 : r_ovf;
    w_load      = 1'b0;
    w_irq_nxt   = 1'b0;
    w_cnt_base  = clr_i ? '0 : r_cnt;
    w_cnt_nxt   = w_cnt_base;
    if (req_i && (w_cnt_base != CNT_MAX)) begin
      w_cnt_nxt = w_cnt_base + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end
    unique case (w_state_eff)
      ST_EMPTY: begin
        if (req_i) begin
          w_load      = 1'b1;
          w_irq_nxt   = 1'b1;
          w_state_nxt = ST_CAPTURED;
        end
      end
      ST_CAPTURED: begin
        if (req_i) begin
          w_ovf_nxt = 1'b1;
        end
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= ST_EMPTY;
      r_ovf   <= 1'b0;
      r_cnt   <= '0;
      r_irq   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ovf   <= w_ovf_nxt;
      r_cnt   <= w_cnt_nxt;
      r_irq   <= w_irq_nxt;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_err_addr <= 32'h0;
      r_err_wen  <= 1'b0;
      r_err_be   <= 4'h0;
    end else if (w_load) begin
      r_err_addr <= add_i;
      r_err_wen  <= wen_i;
      r_err_be   <= be_i;
    end
  end

  assign err_addr_o     = r_err_addr;
  assign err_wen_o      = r_err_wen;
  assign err_be_o       = r_err_be;
  assign err_valid_o    = (r_state == ST_CAPTURED);
  assign err_overflow_o = r_ovf;
  assign err_cnt_o      = r_cnt;
  assign err_irq_o      = r_irq;

`else

  logic [38:0] w_unused;

  assign w_unused = {wdata_i[31:0], clr_i, be_i, add_i[1:0]} ^
                    {add_i[31:0], 7'h0};

  assign err_addr_o     = 32'h0;
  assign err_wen_o      = 1'b0;
  assign err_be_o       = 4'h0;
  assign err_valid_o    = 1'b0;
  assign err_overflow_o = 1'b0;
  assign err_cnt_o      = '0;
  assign err_irq_o      = 1'b0;

`endif

endmodule

// File: tb/tb_tcdm_error_slave.sv
// tb_tcdm_error_slave: directed bench for tcdm_error_slave.
// Expected values are hand-computed; capture checks follow the build option.

module tb_tcdm_error_slave;

`ifdef TCDM_ERR_SLAVE_CAPTURE_EN
  localparam bit CAP = 1'b1;
`else
  localparam bit CAP = 1'b0;
`endif

  localparam logic [31:0] PAT = 32'hBADACCE5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        req2 = 1'b0;
  logic [31:0] add = 32'h0;
  logic        wen = 1'b0;
  logic [31:0] wdata = 32'h0;
  logic [3:0]  be = 4'h0;
  logic        clr = 1'b0;

  logic        gnt, rv, ropc, ev, ewen, eovf, eirq;
  logic [31:0] rdata, eaddr;
  logic [3:0]  ebe;
  logic [7:0]  ecnt;

  logic        gnt2, rv2, ropc2, ev2, ewen2, eovf2, eirq2;
  logic [31:0] rdata2, eaddr2;
  logic [3:0]  ebe2;
  logic [1:0]  ecnt2;

  int n_cmp = 0;
  int n_bad = 0;
  int irqs;

  always #5 clk = ~clk;

  tcdm_error_slave u_dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .add_i(add),
    .wen_i(wen), .wdata_i(wdata), .be_i(be), .gnt_o(gnt),
    .r_valid_o(rv), .r_opc_o(ropc), .r_rdata_o(rdata),
    .clr_i(clr), .err_addr_o(eaddr), .err_wen_o(ewen),
    .err_be_o(ebe), .err_valid_o(ev), .err_overflow_o(eovf),
    .err_cnt_o(ecnt), .err_irq_o(eirq)
  );

  tcdm_error_slave #(.CNT_WIDTH(2)) u_dut2 (
    .clk_i(clk), .rst_i(rst), .req_i(req2), .add_i(add),
    .wen_i(wen), .wdata_i(wdata), .be_i(be), .gnt_o(gnt2),
    .r_valid_o(rv2), .r_opc_o(ropc2), .r_rdata_o(rdata2),
    .clr_i(1'b0), .err_addr_o(eaddr2), .err_wen_o(ewen2),
    .err_be_o(ebe2), .err_valid_o(ev2), .err_overflow_o(eovf2),
    .err_cnt_o(ecnt2), .err_irq_o(eirq2)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] cv(input logic [31:0] v);
    return CAP ? v : 32'h0;
  endfunction

  initial begin
    // reset state
    cyc();
    cyc();
    chk("rst_rvalid", {31'h0, rv}, 32'h0);
    chk("rst_ropc", {31'h0, ropc}, 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_eaddr", eaddr, 32'h0);
    chk("rst_evalid", {31'h0, ev}, 32'h0);
    chk("rst_ecnt", {24'h0, ecnt}, 32'h0);
    chk("rst_irq", {31'h0, eirq}, 32'h0);
    req = 1'b1;
    #1;
    chk("rst_gnt", {31'h0, gnt}, 32'h1);
    req = 1'b0;
    #1;
    chk("rst_gnt0", {31'h0, gnt}, 32'h0);
    cyc();
    rst = 1'b0;
    cyc();

    // single read
    req = 1'b1; add = 32'h1C00_0000; wen = 1'b1; be = 4'hF;
    #1;
    chk("rd_gnt", {31'h0, gnt}, 32'h1);
    cyc();
    req = 1'b0;
    chk("rd_rvalid", {31'h0, rv}, 32'h1);
    chk("rd_ropc", {31'h0, ropc}, 32'h1);
    chk("rd_rdata", rdata, PAT);
    chk("rd_eaddr", eaddr, cv(32'h1C00_0000));
    chk("rd_evalid", {31'h0, ev}, cv(32'h1));
    chk("rd_ecnt", {24'h0, ecnt}, cv(32'h1));
    chk("rd_irq", {31'h0, eirq}, cv(32'h1));
    cyc();
    chk("rd_irq_off", {31'h0, eirq}, 32'h0);
    chk("rd_rvalid_off", {31'h0, rv}, 32'h0);
    chk("rd_rdata_off", rdata, 32'h0);

    // clear
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    chk("clr_evalid", {31'h0, ev}, 32'h0);
    chk("clr_ecnt", {24'h0, ecnt}, 32'h0);

    // single write
    req = 1'b1; add = 32'h0000_2000; wen = 1'b0; be = 4'b0011;
    wdata = 32'h1234_5678;
    cyc();
    req = 1'b0;
    chk("wr_rvalid", {31'h0, rv}, 32'h1);
    chk("wr_ropc", {31'h0, ropc}, 32'h1);
    chk("wr_rdata", rdata, 32'h0);
    chk("wr_ewen", {31'h0, ewen}, 32'h0);
    chk("wr_ebe", {28'h0, ebe}, cv(32'h3));
    chk("wr_eaddr", eaddr, cv(32'h2000));
    cyc();
    clr = 1'b1;
    cyc();
    clr = 1'b0;

    // back-to-back reads
    irqs = 0;
    wen = 1'b1; be = 4'hF;
    for (int i = 0; i < 3; i++) begin
      req = 1'b1;
      add = 32'h10 * (i + 1);
      cyc();
      chk("b2b_rvalid", {31'h0, rv}, 32'h1);
      chk("b2b_rdata", rdata, PAT);
      if (eirq) irqs++;
    end
    req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (eirq) irqs++;
      cyc();
    end
    chk("b2b_eaddr", eaddr, cv(32'h10));
    chk("b2b_ecnt", {24'h0, ecnt}, cv(32'h3));
    chk("b2b_ovf", {31'h0, eovf}, cv(32'h1));
    chk("b2b_irqs", irqs, cv(32'h1));

    // clear coincident with request
    clr = 1'b1; req = 1'b1; add = 32'h40;
    cyc();
    clr = 1'b0; req = 1'b0;
    chk("cc_eaddr", eaddr, cv(32'h40));
    chk("cc_ecnt", {24'h0, ecnt}, cv(32'h1));
    chk("cc_ovf", {31'h0, eovf}, 32'h0);
    chk("cc_irq", {31'h0, eirq}, cv(32'h1));
    chk("cc_evalid", {31'h0, ev}, cv(32'h1));
    cyc();

    // saturation with CNT_WIDTH=2
    req2 = 1'b1;
    for (int i = 0; i < 5; i++) cyc();
    req2 = 1'b0;
    chk("sat_rvalid2", {31'h0, rv2}, 32'h1);
    cyc();
    chk("sat_ecnt2", {30'h0, ecnt2}, cv(32'h3));

    // reset mid-response
    req = 1'b1; add = 32'h80; wen = 1'b1;
    cyc();
    req = 1'b0;
    chk("mr_rvalid", {31'h0, rv}, 32'h1);
    rst = 1'b1;
    #1;
    chk("mr_rvalid_rst", {31'h0, rv}, 32'h0);
    chk("mr_rdata_rst", rdata, 32'h0);
    chk("mr_eaddr_rst", eaddr, 32'h0);
    chk("mr_ecnt_rst", {24'h0, ecnt}, 32'h0);
    chk("mr_ovf_rst", {31'h0, eovf}, 32'h0);
    chk("mr_evalid_rst", {31'h0, ev}, 32'h0);
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
